axi_ni_receive_packet_sequencer: RTL and testbench

//  Receive-side flit sequencer for the AXI target NI. It accepts flits from the router port and

---
 rtl/axi_ni_receive_packet_sequencer_pkg.sv | 26 ++
 rtl/axi_ni_receive_packet_sequencer.sv | 152 +++++++++++++++
 tb/tb_axi_ni_receive_packet_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_ni_receive_packet_sequencer_pkg.sv
// Shared definitions for the AXI target NI receive flit sequencer:
// flit type codes, sequencer state encoding and counter width.
package axi_ni_receive_packet_sequencer_pkg;

    localparam int FTYPEWD       = 2;
    localparam int COUNTERFLITWD = 4;

    typedef enum logic [FTYPEWD-1:0] {
        FTYPE_BODY     = 2'b00,
        FTYPE_TAIL     = 2'b01,
        FTYPE_HEAD     = 2'b10,
        FTYPE_HEADTAIL = 2'b11
    } ftype_t;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        HEADER   = 2'b01,
        DISPATCH = 2'b10,
        PAYLOAD  = 2'b11
    } seq_state_t;

    function automatic logic is_head(input ftype_t t);
        return (t == FTYPE_HEAD) || (t == FTYPE_HEADTAIL);
    endfunction

endpackage

// File: rtl/axi_ni_receive_packet_sequencer.sv
// Receive-side flit sequencer: steers header flits into the header register,
// holds the link while the header is consumed, then streams payload to the tail.
module axi_ni_receive_packet_sequencer
    import axi_ni_receive_packet_sequencer_pkg::*;
#(
    parameter int FLIT_WIDTH   = 32,
    parameter int HEADER_FLITS = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flit_valid,
    input  logic [FLIT_WIDTH-1:0]    flit,
    output logic                     flit_ack,
    output logic                     sample_header,
    output logic [COUNTERFLITWD-1:0] flit_count,
    output logic                     header_valid,
    input  logic                     header_ready,
    output logic                     payload_valid,
    input  logic                     payload_ready,
    output logic [COUNTERFLITWD-1:0] payload_count,
    output logic                     packet_done,
    output logic                     protocol_error
);

    localparam logic [COUNTERFLITWD-1:0] LAST_HDR = COUNTERFLITWD'(HEADER_FLITS - 1);

    seq_state_t                 state;
    logic [COUNTERFLITWD-1:0]   flit_cnt;
    logic [COUNTERFLITWD-1:0]   pay_cnt;
    logic                       tail_seen;
    ftype_t                     ftype;
    logic                       head;
    logic                       accept;
    logic                       unused_flit_bits;

    assign ftype            = ftype_t'(flit[FTYPEWD-1:0]);
    assign head             = is_head(ftype);
    assign accept           = flit_valid & flit_ack;
    assign payload_count    = pay_cnt;
    assign unused_flit_bits = ^flit[FLIT_WIDTH-1:FTYPEWD];

    // Handshake outputs are forced low while reset is held so the link is quiet at once.
    // A HEAD arriving mid-header restarts the packet, so it is written at index 0.
    always_comb begin
        flit_ack      = 1'b0;
        sample_header = 1'b0;
        payload_valid = 1'b0;
        flit_count    = flit_cnt;
        if (!rst) begin
            case (state)
                IDLE: begin
                    flit_ack      = flit_valid;
                    sample_header = flit_valid & head;
                end
                HEADER: begin
                    flit_ack      = flit_valid;
                    sample_header = flit_valid;
                    if (head) flit_count = '0;
                end
                PAYLOAD: begin
                    payload_valid = flit_valid & ~head;
                    flit_ack      = flit_valid & payload_ready & ~head;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            flit_cnt       <= '0;
            pay_cnt        <= '0;
            tail_seen      <= 1'b0;
            header_valid   <= 1'b0;
            packet_done    <= 1'b0;
            protocol_error <= 1'b0;
        end else begin
            packet_done    <= 1'b0;
            protocol_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (head) begin
                            tail_seen <= (ftype == FTYPE_HEADTAIL);
                            if (HEADER_FLITS == 1) begin
                                state        <= DISPATCH;
                                header_valid <= 1'b1;
                            end else begin
                                state    <= HEADER;
                                flit_cnt <= COUNTERFLITWD'(1);
                            end
                        end else begin
                            protocol_error <= 1'b1;
                        end
                    end
                end
                HEADER: begin
                    if (accept) begin
                        if (head) begin
                            protocol_error <= 1'b1;
                            tail_seen      <= (ftype == FTYPE_HEADTAIL);
                            flit_cnt       <= COUNTERFLITWD'(1);
                        end else if (flit_cnt == LAST_HDR) begin
                            state        <= DISPATCH;
                            header_valid <= 1'b1;
                            tail_seen    <= (ftype == FTYPE_TAIL);
                            flit_cnt     <= '0;
                        end else if (ftype == FTYPE_TAIL) begin
                            protocol_error <= 1'b1;
                            state          <= IDLE;
                            flit_cnt       <= '0;
                        end else begin
                            flit_cnt <= flit_cnt + 1'b1;
                        end
                    end
                end
                DISPATCH: begin
                    if (header_ready) begin
                        header_valid <= 1'b0;
                        if (tail_seen) begin
                            state       <= IDLE;
                            packet_done <= 1'b1;
                            tail_seen   <= 1'b0;
                        end else begin
                            state   <= PAYLOAD;
                            pay_cnt <= '0;
                        end
                    end
                end
                PAYLOAD: begin
                    // A new HEAD abandons the truncated packet; IDLE picks it up next cycle.
                    if (flit_valid && head) begin
                        protocol_error <= 1'b1;
                        state          <= IDLE;
                        pay_cnt        <= '0;
                    end else if (accept) begin
                        if (ftype == FTYPE_TAIL) begin
                            packet_done <= 1'b1;
                            state       <= IDLE;
                            pay_cnt     <= '0;
                        end else begin
                            pay_cnt <= pay_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_ni_receive_packet_sequencer.sv
// Self-checking bench: directed scenarios on a 3-flit-header and a 1-flit-header
// instance, then random legal packets scored against a packet-level model.
module tb_axi_ni_receive_packet_sequencer;
    import axi_ni_receive_packet_sequencer_pkg::*;

    localparam int CW = COUNTERFLITWD;

    logic          clk, rst;
    logic          flit_valid, flit_ack, sample_header, header_valid, header_ready;
    logic          payload_valid, payload_ready, packet_done, protocol_error;
    logic [31:0]   flit;
    logic [CW-1:0] flit_count, payload_count;

    logic          b_flit_valid, b_flit_ack, b_sample_header, b_header_valid, b_header_ready;
    logic          b_payload_valid, b_payload_ready, b_packet_done, b_protocol_error;
    logic [31:0]   b_flit;
    logic [CW-1:0] b_flit_count, b_payload_count;

    int tests = 0;
    int fails = 0;

    logic           mon_en = 1'b0;
    logic [CW+31:0] obs_samp[$], obs_pay[$], exp_samp[$], exp_pay[$];
    int             obs_done = 0, obs_err = 0, exp_done = 0;

    axi_ni_receive_packet_sequencer #(.FLIT_WIDTH(32), .HEADER_FLITS(3)) dut (
        .clk(clk), .rst(rst), .flit_valid(flit_valid), .flit(flit), .flit_ack(flit_ack),
        .sample_header(sample_header), .flit_count(flit_count), .header_valid(header_valid),
        .header_ready(header_ready), .payload_valid(payload_valid), .payload_ready(payload_ready),
        .payload_count(payload_count), .packet_done(packet_done), .protocol_error(protocol_error)
    );

    axi_ni_receive_packet_sequencer #(.FLIT_WIDTH(32), .HEADER_FLITS(1)) dut_single (
        .clk(clk), .rst(rst), .flit_valid(b_flit_valid), .flit(b_flit), .flit_ack(b_flit_ack),
        .sample_header(b_sample_header), .flit_count(b_flit_count), .header_valid(b_header_valid),
        .header_ready(b_header_ready), .payload_valid(b_payload_valid),
        .payload_ready(b_payload_ready), .payload_count(b_payload_count),
        .packet_done(b_packet_done), .protocol_error(b_protocol_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Passive monitor feeding the random-phase scoreboard.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (sample_header) obs_samp.push_back({flit_count, flit});
            if (payload_valid && flit_ack) obs_pay.push_back({payload_count, flit});
            if (packet_done) obs_done++;
            if (protocol_error) obs_err++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("[TB] check %s did not hold", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input ftype_t t);
        logic [29:0] d;
        d = 30'($urandom);
        return {d, t};
    endfunction

    task automatic drive(input logic v, input ftype_t t);
        flit_valid = v;
        flit       = mk(t);
        #1;
    endtask

    task automatic hdr_step(input ftype_t t, input int idx, input string tag);
        drive(1'b1, t);
        check({tag, "_sample"}, sample_header, 1);
        check({tag, "_idx"}, flit_count, idx);
        check({tag, "_ack"}, flit_ack, 1);
        tick();
    endtask

    task automatic send_header(input ftype_t last);
        hdr_step(FTYPE_HEAD, 0, "hdr0");
        hdr_step(FTYPE_BODY, 1, "hdr1");
        hdr_step(last, 2, "hdr2");
    endtask

    task automatic to_payload();
        flit_valid   = 1'b0;
        header_ready = 1'b1;
        #1;
        check("disp_hv", header_valid, 1);
        tick();
        header_ready = 1'b0;
    endtask

    task automatic rand_ready();
        payload_ready = ($urandom_range(0, 3) != 0);
        header_ready  = ($urandom_range(0, 2) == 0);
    endtask

    task automatic send_flit(input logic [31:0] f);
        int c;
        repeat ($urandom_range(0, 2)) begin
            flit_valid = 1'b0;
            rand_ready();
            tick();
        end
        flit_valid = 1'b1;
        flit       = f;
        for (c = 0; c < 100; c++) begin
            rand_ready();
            #1;
            if (flit_ack) begin
                tick();
                break;
            end
            tick();
        end
        if (c >= 100) check("rand_ack_timeout", flit_ack, 1);
        flit_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] pf[3];
        logic [31:0] f;
        int          idx, len, c;

        rst = 1'b1; flit_valid = 1'b0; flit = '0; header_ready = 1'b0; payload_ready = 1'b0;
        b_flit_valid = 1'b0; b_flit = '0; b_header_ready = 1'b0; b_payload_ready = 1'b1;
        repeat (2) tick();
        flit_valid = 1'b1;
        #1;
        check("rst_ack", flit_ack, 0);
        check("rst_sample", sample_header, 0);
        check("rst_hv", header_valid, 0);
        check("rst_cnt", flit_count, 0);
        check("rst_err", protocol_error, 0);
        flit_valid = 1'b0;
        rst = 1'b0;
        tick();

        // Scenario 1: 3-flit header, late header_ready, four bodies then tail.
        payload_ready = 1'b1;
        send_header(FTYPE_BODY);
        drive(1'b1, FTYPE_BODY);
        check("t1_hv1", header_valid, 1);
        check("t1_hold_ack", flit_ack, 0);
        check("t1_hold_sample", sample_header, 0);
        tick();
        header_ready = 1'b1;
        #1;
        check("t1_hv2", header_valid, 1);
        check("t1_simul_ack", flit_ack, 0);
        tick();
        header_ready = 1'b0;
        check("t1_hv_drop", header_valid, 0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, (i == 4) ? FTYPE_TAIL : FTYPE_BODY);
            check("t1_pvalid", payload_valid, 1);
            check("t1_pack", flit_ack, 1);
            check("t1_pcount", payload_count, i);
            tick();
        end
        flit_valid = 1'b0;
        #1;
        check("t1_done", packet_done, 1);
        tick();
        check("t1_done_pulse", packet_done, 0);

        // Scenario 2: single-flit header instance with a HEADTAIL.
        b_flit_valid = 1'b1;
        b_flit = mk(FTYPE_HEADTAIL);
        #1;
        check("t2_sample", b_sample_header, 1);
        check("t2_idx", b_flit_count, 0);
        check("t2_ack", b_flit_ack, 1);
        tick();
        b_flit_valid = 1'b0;
        #1;
        check("t2_hv", b_header_valid, 1);
        b_header_ready = 1'b1;
        tick();
        check("t2_done", b_packet_done, 1);
        check("t2_hv_drop", b_header_valid, 0);
        b_header_ready = 1'b0;
        tick();
        check("t2_done_pulse", b_packet_done, 0);
        check("t2_no_payload", b_payload_valid, 0);

        // Scenario 3: payload_ready toggling, no loss or duplication.
        send_header(FTYPE_BODY);
        to_payload();
        pf[0] = mk(FTYPE_BODY); pf[1] = mk(FTYPE_BODY); pf[2] = mk(FTYPE_TAIL);
        idx = 0;
        for (c = 0; c < 20 && idx < 3; c++) begin
            payload_ready = (c % 2 == 0);
            flit_valid    = 1'b1;
            flit          = pf[idx];
            #1;
            check("t3_ack", flit_ack, payload_ready);
            check("t3_pcount", payload_count, idx);
            if (flit_ack) idx++;
            tick();
        end
        flit_valid    = 1'b0;
        payload_ready = 1'b1;
        check("t3_all_taken", idx, 3);
        check("t3_cycles", c, 5);
        check("t3_done", packet_done, 1);

        // Scenario 4: stray BODY in IDLE, then a normal packet.
        tick();
        drive(1'b1, FTYPE_BODY);
        check("t4_ack", flit_ack, 1);
        check("t4_sample", sample_header, 0);
        tick();
        check("t4_err", protocol_error, 1);
        send_header(FTYPE_BODY);
        check("t4_err_pulse", protocol_error, 0);
        to_payload();
        drive(1'b1, FTYPE_TAIL);
        check("t4_tail_ack", flit_ack, 1);
        tick();
        flit_valid = 1'b0;
        check("t4_done", packet_done, 1);

        // Scenario 5: TAIL as second of three header flits.
        hdr_step(FTYPE_HEAD, 0, "t5_h0");
        hdr_step(FTYPE_TAIL, 1, "t5_h1");
        flit_valid   = 1'b0;
        header_ready = 1'b1;
        #1;
        check("t5_err", protocol_error, 1);
        for (int i = 0; i < 3; i++) begin
            check("t5_no_hv", header_valid, 0);
            tick();
        end
        header_ready = 1'b0;

        // Scenario 6: reset in PAYLOAD, then a header-only packet from index 0.
        send_header(FTYPE_BODY);
        to_payload();
        drive(1'b1, FTYPE_BODY);
        tick();
        check("t6_pcount", payload_count, 1);
        drive(1'b1, FTYPE_BODY);
        check("t6_pvalid_pre", payload_valid, 1);
        rst = 1'b1;
        #1;
        check("t6_rst_ack", flit_ack, 0);
        check("t6_rst_pvalid", payload_valid, 0);
        check("t6_rst_pcount", payload_count, 0);
        check("t6_rst_hv", header_valid, 0);
        rst = 1'b0;
        flit_valid = 1'b0;
        tick();
        send_header(FTYPE_TAIL);
        header_ready = 1'b1;
        #1;
        check("t6_hv", header_valid, 1);
        tick();
        header_ready = 1'b0;
        check("t6_done", packet_done, 1);
        check("t6_no_pvalid", payload_valid, 0);

        // Scenario 7: HEAD during PAYLOAD is refused, flagged, then taken by IDLE.
        send_header(FTYPE_BODY);
        to_payload();
        drive(1'b1, FTYPE_HEAD);
        check("t7_head_nack", flit_ack, 0);
        tick();
        check("t7_err", protocol_error, 1);
        check("t7_idle_sample", sample_header, 1);
        check("t7_idle_idx", flit_count, 0);
        tick();
        hdr_step(FTYPE_BODY, 1, "t7_h1");
        hdr_step(FTYPE_TAIL, 2, "t7_h2");
        header_ready = 1'b1;
        flit_valid   = 1'b0;
        tick();
        header_ready = 1'b0;
        check("t7_done", packet_done, 1);
        tick();

        // Random phase: legal packets with random gaps, stalls and payload lengths.
        mon_en = 1'b1;
        for (int p = 0; p < 25; p++) begin
            len = $urandom_range(0, 20);
            for (int h = 0; h < 3; h++) begin
                f = mk((h == 0) ? FTYPE_HEAD : ((h == 2 && len == 0) ? FTYPE_TAIL : FTYPE_BODY));
                exp_samp.push_back({CW'(h), f});
                send_flit(f);
            end
            for (int j = 0; j < len; j++) begin
                f = mk((j == len - 1) ? FTYPE_TAIL : FTYPE_BODY);
                exp_pay.push_back({CW'(j), f});
                send_flit(f);
            end
            exp_done++;
        end
        flit_valid   = 1'b0;
        header_ready = 1'b1;
        for (c = 0; c < 100 && obs_done != exp_done; c++) tick();
        header_ready = 1'b0;
        tick();
        mon_en = 1'b0;
        check("rand_done", obs_done, exp_done);
        check("rand_err", obs_err, 0);
        check("rand_nsamp", obs_samp.size(), exp_samp.size());
        check("rand_npay", obs_pay.size(), exp_pay.size());
        for (int i = 0; i < exp_samp.size() && i < obs_samp.size(); i++)
            check("rand_samp", obs_samp[i], exp_samp[i]);
        for (int i = 0; i < exp_pay.size() && i < obs_pay.size(); i++)
            check("rand_pay", obs_pay[i], exp_pay[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
